// File: rtl/life_gen_ctrl.sv
// -----------------------------------------------------------------------------
// life_gen_ctrl
//
// Computes one Conway's Life generation over a grid held in a ping-pong pair
// of single-cycle-latency BRAMs. Each BRAM word is one grid row, one bit per
// cell. On start, every row of the front bank is streamed through a three-row
// window (top/mid/bot). The life rule is applied with toroidal wrap, and each
// result row is written to the back bank. The banks swap when the generation
// is complete. External muxing steers the BRAM ports by front_bank.
//
// Parameters
//   WIDTH      cells per row (BRAM data width), >= 3
//   HEIGHT     rows in the grid (BRAM depth), 3 .. 2**ADDR_WIDTH
//   ADDR_WIDTH BRAM address width
//
// Ports
//   clk        rising-edge clock
//   resetn     asynchronous active-low reset
//   start      request one generation (sampled only while idle)
//   busy       high whenever the sequencer is not idle
//   done       one-cycle pulse when the generation is complete
//   front_bank bank holding the current generation (reads), writes go to ~front_bank
//   rd_en      read strobe to the front bank
//   rd_addr    read row address
//   rd_data    front-bank read data, valid the cycle after rd_en
//   wr_en      write strobe to the back bank
//   wr_addr    write row address
//   wr_data    next-generation row
// -----------------------------------------------------------------------------
module life_gen_ctrl #(
  parameter int WIDTH      = 8,
  parameter int HEIGHT     = 200,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  front_bank,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [WIDTH-1:0]      rd_data,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WIDTH-1:0]      wr_data
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ROW = ADDR_WIDTH'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_WRITE,
    S_DONE
  } state_t;

  state_t                  state_reg, state_next;
  logic [ADDR_WIDTH-1:0]   row_reg, row_next;
  logic [1:0]              prime_reg, prime_next;
  logic [WIDTH-1:0]        top_reg, top_next;
  logic [WIDTH-1:0]        mid_reg, mid_next;
  logic [WIDTH-1:0]        bot_reg, bot_next;
  logic                    front_bank_reg, front_bank_next;

  logic [ADDR_WIDTH-1:0]   row_inc;
  logic [ADDR_WIDTH-1:0]   fetch_addr;
  logic [WIDTH-1:0]        rule_row;

  // ---------------------------------------------------------------------------
  // Life rule, one column per generate iteration. Columns wrap at both edges.
  // The neighbour count is 4 bits so a full 8-neighbour count is never lost.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      localparam int CL = (gi + WIDTH - 1) % WIDTH;
      localparam int CR = (gi + 1) % WIDTH;
      logic [3:0] count;

      assign count = 4'(top_reg[CL]) + 4'(top_reg[gi]) + 4'(top_reg[CR]) +
                     4'(mid_reg[CL])                   + 4'(mid_reg[CR]) +
                     4'(bot_reg[CL]) + 4'(bot_reg[gi]) + 4'(bot_reg[CR]);

      assign rule_row[gi] = (count == 4'd3) || (mid_reg[gi] && (count == 4'd2));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Read address. Priming reads the row above row 0 (HEIGHT-1), then row 0.
  // After that, each fetch brings in the row below the row about to be
  // written. row_reg has already been advanced by WRITE, so that row is
  // row_reg+1, wrapping so the final fetch re-reads row 0.
  // ---------------------------------------------------------------------------
  assign row_inc = (row_reg == LAST_ROW) ? '0 : row_reg + ADDR_WIDTH'(1);

  always_comb begin
    fetch_addr = row_inc;
    case (prime_reg)
      2'd0:    fetch_addr = LAST_ROW;
      2'd1:    fetch_addr = '0;
      default: fetch_addr = row_inc;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= S_IDLE;
      row_reg        <= '0;
      prime_reg      <= '0;
      top_reg        <= '0;
      mid_reg        <= '0;
      bot_reg        <= '0;
      front_bank_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      row_reg        <= row_next;
      prime_reg      <= prime_next;
      top_reg        <= top_next;
      mid_reg        <= mid_next;
      bot_reg        <= bot_next;
      front_bank_reg <= front_bank_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and output decode
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next      = state_reg;
    row_next        = row_reg;
    prime_next      = prime_reg;
    top_next        = top_reg;
    mid_next        = mid_reg;
    bot_next        = bot_reg;
    front_bank_next = front_bank_reg;

    busy    = (state_reg != S_IDLE);
    done    = 1'b0;
    rd_en   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;

    case (state_reg)
      S_IDLE: begin
        if (start) begin
          row_next   = '0;
          prime_next = '0;
          state_next = S_FETCH;
        end
      end

      S_FETCH: begin
        rd_en      = 1'b1;
        rd_addr    = fetch_addr;
        state_next = S_LATCH;
      end

      S_LATCH: begin
        top_next = mid_reg;
        mid_next = bot_reg;
        bot_next = rd_data;
        // The first two latches only fill the window; the third completes it.
        if (prime_reg < 2'd2) begin
          prime_next = prime_reg + 2'd1;
          state_next = S_FETCH;
        end else begin
          state_next = S_WRITE;
        end
      end

      S_WRITE: begin
        wr_en   = 1'b1;
        wr_addr = row_reg;
        wr_data = rule_row;
        if (row_reg == LAST_ROW) begin
          state_next = S_DONE;
        end else begin
          row_next   = row_reg + ADDR_WIDTH'(1);
          state_next = S_FETCH;
        end
      end

      S_DONE: begin
        done            = 1'b1;
        front_bank_next = ~front_bank_reg;
        state_next      = S_IDLE;
      end

      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  assign front_bank = front_bank_reg;

endmodule

// File: tb/tb_life_gen_ctrl.sv
// -----------------------------------------------------------------------------
// Testbench for life_gen_ctrl: WIDTH=8, HEIGHT=8, with a 1-cycle BRAM model
// per bank. Expected grids come from a neighbour-counting reference model over
// a plain 2-D grid.
// -----------------------------------------------------------------------------
module tb_life_gen_ctrl;

  localparam int W  = 8;
  localparam int H  = 8;
  localparam int AW = 3;
  localparam int LOGN = 4096;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, front_bank;
  logic          rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [W-1:0]  rd_data;
  logic [W-1:0]  wr_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  life_gen_ctrl #(.WIDTH(W), .HEIGHT(H), .ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .front_bank (front_bank),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data)
  );

  // ---------------- BRAM pair model, plus a load port for the bench --------
  logic [W-1:0]  mem [2][H];
  logic          ld_en = 1'b0;
  logic          ld_bank = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [W-1:0]  ld_data = '0;

  always @(posedge clk) begin
    if (rd_en) rd_data <= mem[front_bank][rd_addr];
    if (wr_en) mem[~front_bank][wr_addr] <= wr_data;
    if (ld_en) mem[ld_bank][ld_addr] <= ld_data;
  end

  // ---------------- Monitor: logs sampled on the falling edge --------------
  int pe = 0;
  always @(posedge clk) pe <= pe + 1;

  bit busy_at [LOGN];
  bit fb_at   [LOGN];
  bit nz_at   [LOGN];
  int rd_pe_q[$];
  int rd_addr_q[$];
  int rd_bank_q[$];
  int wr_pe_q[$];
  int wr_addr_q[$];
  int done_pe_q[$];

  always @(negedge clk) begin
    if (pe < LOGN) begin
      busy_at[pe] = busy;
      fb_at[pe]   = front_bank;
      nz_at[pe]   = busy | done | front_bank | rd_en | wr_en |
                    (|rd_addr) | (|wr_addr) | (|wr_data);
    end
    if (rd_en) begin
      rd_pe_q.push_back(pe);
      rd_addr_q.push_back(int'(rd_addr));
      rd_bank_q.push_back(int'(front_bank));
    end
    if (wr_en) begin
      wr_pe_q.push_back(pe);
      wr_addr_q.push_back(int'(wr_addr));
    end
    if (done) done_pe_q.push_back(pe);
  end

  // ---------------- Reference model ----------------------------------------
  logic [W-1:0] cur_grid [H];
  logic [W-1:0] exp_grid [H];

  task automatic compute_expected();
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        int n;
        n = 0;
        for (int dr = -1; dr <= 1; dr++)
          for (int dc = -1; dc <= 1; dc++)
            if (dr != 0 || dc != 0)
              n += int'(cur_grid[(r + dr + H) % H][(c + dc + W) % W]);
        exp_grid[r][c] = (n == 3) || (cur_grid[r][c] && n == 2);
      end
    end
  endtask

  // ---------------- Stimulus driver -----------------------------------------
  int start_pe;
  int rd_base, wr_base, done_base;
  logic fb_before;

  // Loads cur_grid into the front bank, junk into the back bank, starts a
  // generation and runs a fixed 40-cycle window. extra_start re-pulses start
  // at that relative cycle; reset_at pulls resetn low for cycles reset_at+1..
  // reset_at+1 (released at reset_at+2).
  task automatic run_gen(input int extra_start, input int reset_at);
    fb_before = front_bank;
    for (int r = 0; r < 2 * H; r++) begin
      @(negedge clk);
      ld_en   = 1'b1;
      ld_bank = (r < H) ? fb_before : ~fb_before;
      ld_addr = AW'(r % H);
      ld_data = (r < H) ? cur_grid[r] : W'($urandom);
    end
    compute_expected();
    @(negedge clk);
    ld_en     = 1'b0;
    rd_base   = rd_pe_q.size();
    wr_base   = wr_pe_q.size();
    done_base = done_pe_q.size();
    start     = 1'b1;
    start_pe  = pe;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      start = (k == extra_start);
      if (k == reset_at) resetn = 1'b0;
      if (k == reset_at + 2) resetn = 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic random_grid();
    for (int r = 0; r < H; r++) cur_grid[r] = W'($urandom);
  endtask

  // ---------------- Tests ---------------------------------------------------
  task automatic test_reset();
    resetn = 1'b0;
    start  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if ({busy, done, front_bank, rd_en, wr_en} !== 5'b0) begin
        bad++;
        $display("FAIL reset_flags: busy/done/fb/rd_en/wr_en=%b required 00000",
                 {busy, done, front_bank, rd_en, wr_en});
      end
      total++;
      if (rd_addr !== '0 || wr_addr !== '0 || wr_data !== '0) begin
        bad++;
        $display("FAIL reset_buses: rd_addr=%0d wr_addr=%0d wr_data=%h required 0/0/00",
                 rd_addr, wr_addr, wr_data);
      end
    end
    $display("test_reset: 3 cycles held in reset with start=1");
    start  = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_blinker();
    int done_rel;
    int busy_cnt;
    for (int r = 0; r < H; r++) cur_grid[r] = '0;
    cur_grid[3] = 8'h1C;
    run_gen(-1, -1);
    for (int r = 0; r < H; r++) begin
      logic [W-1:0] want;
      want = (r >= 2 && r <= 4) ? 8'h08 : 8'h00;
      total++;
      if (mem[~fb_before][r] !== want) begin
        bad++;
        $display("FAIL blinker_row%0d: got %h required %h", r, mem[~fb_before][r], want);
      end
    end
    total++;
    if (done_pe_q.size() - done_base != 1) begin
      bad++;
      $display("FAIL blinker_done_count: got %0d required 1", done_pe_q.size() - done_base);
      done_rel = -1;
    end else begin
      done_rel = done_pe_q[done_base] - start_pe;
    end
    total++;
    if (done_rel != 29) begin
      bad++;
      $display("FAIL blinker_done_cycle: got %0d required 29", done_rel);
    end
    total++;
    if (fb_at[start_pe + 29] !== fb_before || fb_at[start_pe + 30] !== ~fb_before) begin
      bad++;
      $display("FAIL blinker_front_bank: cyc29=%b cyc30=%b required %b then %b",
               fb_at[start_pe + 29], fb_at[start_pe + 30], fb_before, ~fb_before);
    end
    busy_cnt = 0;
    for (int k = 0; k <= 40; k++) busy_cnt += int'(busy_at[start_pe + k]);
    total++;
    if (busy_cnt != 29 || !busy_at[start_pe + 1] || !busy_at[start_pe + 29]) begin
      bad++;
      $display("FAIL blinker_busy: %0d busy cycles (c1=%b c29=%b) required 29 covering 1..29",
               busy_cnt, busy_at[start_pe + 1], busy_at[start_pe + 29]);
    end
    $display("test_blinker: done at cycle %0d, front_bank now %b", done_rel, front_bank);
  endtask

  task automatic test_double_wrap();
    for (int r = 0; r < H; r++) cur_grid[r] = '0;
    cur_grid[7] = 8'h01;
    cur_grid[0] = 8'h01;
    cur_grid[1] = 8'h01;
    run_gen(-1, -1);
    for (int r = 0; r < H; r++) begin
      logic [W-1:0] want;
      want = (r == 0) ? 8'h83 : 8'h00;
      total++;
      if (mem[~fb_before][r] !== want) begin
        bad++;
        $display("FAIL double_wrap_row%0d: got %h required %h", r, mem[~fb_before][r], want);
      end
    end
    $display("test_double_wrap: next row0=%h", mem[~fb_before][0]);
  endtask

  task automatic test_address_order();
    int rd_want [10];
    int nrd, nwr;
    rd_want = '{7, 0, 1, 2, 3, 4, 5, 6, 7, 0};
    random_grid();
    run_gen(-1, -1);
    nrd = rd_pe_q.size() - rd_base;
    nwr = wr_pe_q.size() - wr_base;
    total++;
    if (nrd != H + 2) begin
      bad++;
      $display("FAIL addr_read_count: got %0d required %0d", nrd, H + 2);
    end
    for (int i = 0; i < nrd && i < H + 2; i++) begin
      total++;
      if (rd_addr_q[rd_base + i] != rd_want[i] || rd_bank_q[rd_base + i] != int'(fb_before)) begin
        bad++;
        $display("FAIL addr_read%0d: addr=%0d bank=%0d required addr=%0d bank=%0d", i,
                 rd_addr_q[rd_base + i], rd_bank_q[rd_base + i], rd_want[i], fb_before);
      end
    end
    total++;
    if (nwr != H) begin
      bad++;
      $display("FAIL addr_write_count: got %0d required %0d", nwr, H);
    end
    for (int i = 0; i < nwr && i < H; i++) begin
      total++;
      if (wr_addr_q[wr_base + i] != i || wr_pe_q[wr_base + i] - start_pe != 7 + 3 * i) begin
        bad++;
        $display("FAIL addr_write%0d: addr=%0d cycle=%0d required addr=%0d cycle=%0d", i,
                 wr_addr_q[wr_base + i], wr_pe_q[wr_base + i] - start_pe, i, 7 + 3 * i);
      end
    end
    $display("test_address_order: %0d reads, %0d writes", nrd, nwr);
  endtask

  task automatic test_random();
    for (int t = 0; t < 5; t++) begin
      int errs;
      random_grid();
      run_gen(-1, -1);
      errs = 0;
      for (int r = 0; r < H; r++) begin
        total++;
        if (mem[~fb_before][r] !== exp_grid[r]) begin
          bad++;
          errs++;
          $display("FAIL random%0d_row%0d: got %h required %h", t, r,
                   mem[~fb_before][r], exp_grid[r]);
        end
      end
      $display("test_random: generation %0d, %0d row errors", t, errs);
    end
  endtask

  task automatic test_back_to_back();
    // Chain generations: each result becomes the next input.
    random_grid();
    for (int t = 0; t < 3; t++) begin
      run_gen(-1, -1);
      for (int r = 0; r < H; r++) begin
        total++;
        if (mem[~fb_before][r] !== exp_grid[r]) begin
          bad++;
          $display("FAIL chain%0d_row%0d: got %h required %h", t, r,
                   mem[~fb_before][r], exp_grid[r]);
        end
        cur_grid[r] = exp_grid[r];
      end
      total++;
      if (front_bank !== ~fb_before) begin
        bad++;
        $display("FAIL chain%0d_swap: front_bank=%b required %b", t, front_bank, ~fb_before);
      end
      $display("test_back_to_back: generation %0d, front_bank %b", t, front_bank);
    end
  endtask

  task automatic test_start_while_busy();
    int ndone, nwr;
    random_grid();
    run_gen(10, -1);
    ndone = done_pe_q.size() - done_base;
    nwr   = wr_pe_q.size() - wr_base;
    total++;
    if (ndone != 1 || done_pe_q[done_base] - start_pe != 29) begin
      bad++;
      $display("FAIL busy_start_done: count=%0d cycle=%0d required 1 at 29", ndone,
               (ndone > 0) ? done_pe_q[done_base] - start_pe : -1);
    end
    total++;
    if (nwr != H) begin
      bad++;
      $display("FAIL busy_start_writes: got %0d required %0d", nwr, H);
    end
    $display("test_start_while_busy: %0d done pulses, %0d writes", ndone, nwr);
  endtask

  task automatic test_reset_mid_run();
    int ndone;
    if (front_bank == 1'b0) begin
      random_grid();
      run_gen(-1, -1);
    end
    random_grid();
    run_gen(-1, 15);
    total++;
    if (nz_at[start_pe + 16] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: nonzero output during reset, required all 0");
    end
    total++;
    if (nz_at[start_pe + 19] !== 1'b0 || nz_at[start_pe + 30] !== 1'b0) begin
      bad++;
      $display("FAIL midreset_idle: nonzero output after release, required all 0");
    end
    total++;
    if (done_pe_q.size() - done_base != 0) begin
      bad++;
      $display("FAIL midreset_nodone: got %0d done pulses required 0",
               done_pe_q.size() - done_base);
    end
    random_grid();
    run_gen(-1, -1);
    total++;
    if (fb_before !== 1'b0) begin
      bad++;
      $display("FAIL midreset_bank: front_bank=%b required 0", fb_before);
    end
    for (int r = 0; r < H; r++) begin
      total++;
      if (mem[1][r] !== exp_grid[r]) begin
        bad++;
        $display("FAIL midreset_row%0d: got %h required %h", r, mem[1][r], exp_grid[r]);
      end
    end
    ndone = done_pe_q.size() - done_base;
    total++;
    if (ndone != 1 || done_pe_q[done_base] - start_pe != 29) begin
      bad++;
      $display("FAIL midreset_done: count=%0d cycle=%0d required 1 at 29", ndone,
               (ndone > 0) ? done_pe_q[done_base] - start_pe : -1);
    end
    $display("test_reset_mid_run: restarted run done pulses=%0d", ndone);
  endtask

  initial begin
    test_reset();
    test_blinker();
    test_double_wrap();
    test_address_order();
    test_random();
    test_back_to_back();
    test_start_while_busy();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/life_gen_ctrl.md
# life_gen_ctrl

Sequences one Conway generation across a ping-pong pair of cell-grid BRAMs. Each BRAM word holds one grid row, with one bit per cell. On `start`, the block streams every row of the front bank through a three-row sliding window and applies the life rule with toroidal wrap. It writes each next-generation row to the back bank, then swaps banks. The block sits between the display/scanout logic and the two single-cycle-latency BRAM instances; external muxing steers the ports by `front_bank`.

## Interface
- `WIDTH`, 8: cells per row; equals the BRAM data width. Legal range is ≥3.
- `HEIGHT`, 200: rows in the grid; equals the BRAM depth. Legal range is 3..2^`ADDR_WIDTH`.
- `ADDR_WIDTH`, 8: BRAM address width.
- `clk` in 1: the single clock; all logic is rising-edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: request one generation. Sampled only in IDLE.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse when the generation is complete.
- `front_bank` out 1: bank holding the current generation. Reads come from this bank; writes go to `~front_bank`.
- `rd_en` out 1: read strobe to the front bank.
- `rd_addr` out `ADDR_WIDTH`: read row address.
- `rd_data` in `WIDTH`: front-bank read data, valid the cycle after `rd_en`.
- `wr_en` out 1: write strobe to the back bank.
- `wr_addr` out `ADDR_WIDTH`: write row address.
- `wr_data` out `WIDTH`: next-generation row.

## Operation
- **Registers:**
  - State.
  - `row` counter (`ADDR_WIDTH` bits).
  - Prime counter (2 bits).
  - Window rows `top`, `mid`, `bot` (`WIDTH` bits each).
  - `front_bank`.
- **IDLE:** when `start` = 1, clear `row` and the prime counter, then go to FETCH. Otherwise stay in IDLE.
- **FETCH:** `rd_en` = 1, then go to LATCH. The read address sequence is HEIGHT-1, 0, 1, then (`row`+2) mod HEIGHT for each remaining row. The last fetch is row 0 again; row 0 is re-read, not cached. There are HEIGHT+2 reads in total.
- **LATCH:** shift the window (`top`←`mid`, `mid`←`bot`, `bot`←`rd_data`).
  - If the prime counter is below 2, increment it and go to FETCH.
  - Otherwise go to WRITE.
- **WRITE:** drive `wr_en` = 1, `wr_addr` = `row`, and `wr_data` = rule(`top`, `mid`, `bot`).
  - If `row` = HEIGHT-1, go to DONE.
  - Otherwise increment `row` and go to FETCH.
- **DONE:** `done` = 1, `front_bank` toggles, then go to IDLE.
- **Rule for column c:**
  - Neighbour columns are (c-1) mod WIDTH and (c+1) mod WIDTH; columns wrap.
  - The neighbour count sums the 3 bits of `top`, the 3 bits of `bot`, and the 2 side bits of `mid`. It is 4 bits wide, range 0..8, and never truncated.
  - The cell is alive next when count = 3, or when `mid`[c] = 1 and count = 2.
- **Row wrap:**
  - The row above row 0 is row HEIGHT-1.
  - The row below row HEIGHT-1 is row 0.
- The block never reads the back bank and never writes the front bank.
- `start` during any non-IDLE state is ignored; it is neither queued nor restarted.
- **Reset, including mid-generation:**
  - State returns to IDLE.
  - `front_bank`, `busy`, `done`, `rd_en`, `wr_en`, `rd_addr`, `wr_addr`, `wr_data`, `row`, and the window all go to 0.
  - Back-bank contents are left partial and undefined. The next generation overwrites every row.

## Timing
- All outputs are registered, or decoded from the registered state and counters with no `rd_data` → output combinational path except `wr_data`. `wr_data` is combinational from the window registers only.
- Cycle numbering: the cycle in which `start` is sampled high in IDLE is cycle 0.
  - FETCH of row HEIGHT-1 occupies cycle 1.
  - The `row` 0 write occurs in cycle 7.
  - Row r is written in cycle 7+3r.
  - DONE occupies cycle 3·HEIGHT+5.
- `busy` is high in cycles 1..3·HEIGHT+5.
- `done` is high only in cycle 3·HEIGHT+5.
- The new `front_bank` value is visible from cycle 3·HEIGHT+6.
- The earliest next accepted `start` is in cycle 3·HEIGHT+6.
- Throughput is 3 cycles per row after priming.
- `rd_data` is sampled only in LATCH, one cycle after the matching FETCH.

## Test plan
All scenarios use WIDTH=8, HEIGHT=8 and a behavioural 1-cycle BRAM model per bank.

- **Reset:** hold `resetn`=0 with `start`=1 → all outputs are 0, `front_bank`=0, and there is no BRAM access.
- **Blinker:** load front row 3 = 8'h1C with all other rows 0, then pulse `start` → back rows 2, 3, 4 = 8'h08 and all others 0. `done` is high in cycle 29 only, and `front_bank`=1 from cycle 30.
- **Double wrap:** rows 7, 0, 1 = 8'h01 → next row 0 = 8'h83 and all other rows 0.
- **Address order:** run any generation → `rd_addr` per `rd_en` is exactly 7,0,1,2,3,4,5,6,7,0. `wr_addr` per `wr_en` is exactly 0..7, once each.
- **Start while busy:** pulse `start` again at cycle 10 → there is exactly one `done`, in cycle 29, and exactly 8 writes.
- **Reset mid-run:** assert `resetn`=0 at cycle 15, release it, then start again → the outputs match the reset values. The new run completes at cycle 29 relative to the new start, and it reads bank 0.
